// File: rtl/mult_div_unit.sv
// ----------------------------------------------------------------------------
// mult_div_unit
//   EX-stage multiply/divide unit that owns the architectural HI/LO registers.
//   MULT/MULTU/DIV/DIVU compute their result in the start cycle into pending
//   registers. The unit then stays busy for a fixed number of cycles and
//   commits the result to HI/LO as busy falls. MTHI/MTLO write HI/LO in a
//   single cycle. HI/LO are read combinationally by MFHI/MFLO.
//
// Ports
//   clk    : clock; all state changes on the rising edge
//   reset  : synchronous, active-high; clears all state and aborts an op
//   md_op  : 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NONE
//   src_a  : rs value; multiplicand / dividend / MT* source
//   src_b  : rt value; multiplier / divisor
//   start  : comb; a mult/div op is presented while the unit is idle
//   busy   : registered; an operation is in flight
//   hi, lo : architectural HI/LO registers
// ----------------------------------------------------------------------------
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        pend_hi;
    logic [31:0]        pend_lo;
    logic               pend_we;   // cleared for divide-by-zero: HI/LO left untouched

    // ------------------------------------------------------------------
    // Result datapath, evaluated on the current operands
    // ------------------------------------------------------------------
    logic               is_mdop;
    logic               is_div;
    logic               div_signed;
    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        mag_a;
    logic [31:0]        mag_b;
    logic [31:0]        div_b;
    logic [31:0]        quo_u;
    logic [31:0]        rem_u;
    logic [31:0]        res_hi;
    logic [31:0]        res_lo;
    logic               res_we;

    assign is_mdop    = (md_op == OP_MULT) || (md_op == OP_MULTU) ||
                        (md_op == OP_DIV)  || (md_op == OP_DIVU);
    assign is_div     = (md_op == OP_DIV)  || (md_op == OP_DIVU);
    assign div_signed = (md_op == OP_DIV);

    assign start = (state == IDLE) && is_mdop;

    assign prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
    assign prod_u = {32'd0, src_a} * {32'd0, src_b};

    // Signed divide is done on magnitudes so that 0x80000000 / -1 wraps to
    // 0x80000000 instead of relying on the overflow behaviour of a signed '/'.
    assign mag_a = (div_signed && src_a[31]) ? (~src_a + 32'd1) : src_a;
    assign mag_b = (div_signed && src_b[31]) ? (~src_b + 32'd1) : src_b;
    assign div_b = (mag_b == 32'd0) ? 32'd1 : mag_b;
    assign quo_u = mag_a / div_b;
    assign rem_u = mag_a % div_b;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        res_we = 1'b1;
        case (md_op)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV, OP_DIVU: begin
                // Quotient truncates toward zero; remainder takes the dividend's sign.
                res_lo = (div_signed && (src_a[31] ^ src_b[31])) ? (~quo_u + 32'd1) : quo_u;
                res_hi = (div_signed && src_a[31]) ? (~rem_u + 32'd1) : rem_u;
                res_we = (src_b != 32'd0);
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM and architectural state
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            cnt     <= '0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_we <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pend_hi <= res_hi;
                        pend_lo <= res_lo;
                        pend_we <= res_we;
                        cnt     <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else if (md_op == OP_MTHI) begin
                        hi <= src_a;
                    end else if (md_op == OP_MTLO) begin
                        lo <= src_a;
                    end
                end
                RUN: begin
                    // md_op is ignored here; the hazard unit holds it in ID.
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        if (pend_we) begin
                            hi <= pend_hi;
                            lo <= pend_lo;
                        end
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// ----------------------------------------------------------------------------
// tb_mult_div_unit
//   Directed bench for mult_div_unit with default latencies (MULT 5, DIV 10).
//   Inputs change 1ns after the rising edge; outputs are sampled at that point.
// ----------------------------------------------------------------------------
module tb_mult_div_unit;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic        clk;
    logic        reset;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int total;
    int bad;

    mult_div_unit #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .md_op (md_op),
        .src_a (src_a),
        .src_b (src_b),
        .start (start),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an op for one edge, then return md_op to NONE.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        md_op = op;
        src_a = a;
        src_b = b;
        tick();
        md_op = OP_NONE;
    endtask

    // Count cycles busy stays high, starting in the first busy cycle; bounded.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        md_op = OP_NONE;
        src_a = 32'd0;
        src_b = 32'd0;
        tick();
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (start !== 1'b0) begin bad++; $display("FAIL reset_start got=%b exp=0", start); end
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h exp=00000000", hi); end
        total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h exp=00000000", lo); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_mult();
        int n;
        md_op = OP_MULT; src_a = 32'hFFFF_FFFF; src_b = 32'd2;
        #1;
        total++; if (start !== 1'b1) begin bad++; $display("FAIL mult_start got=%b exp=1", start); end
        tick();
        md_op = OP_NONE;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mult_busy_rise got=%b exp=1", busy); end
        total++; if (hi !== 32'd0 || lo !== 32'd0) begin bad++; $display("FAIL mult_hilo_early got=%h_%h exp=00000000_00000000", hi, lo); end
        wait_idle(n);
        total++; if (n != 5) begin bad++; $display("FAIL mult_busy_len got=%0d exp=5", n); end
        total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
        total++; if (lo !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mult_lo got=%h exp=fffffffe", lo); end
    endtask

    task automatic test_multu();
        int n;
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        // Operands change after the start cycle; the pending result must not.
        src_a = 32'h0000_0003;
        src_b = 32'h0000_0003;
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            total++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE) begin
                bad++; $display("FAIL multu_hold got=%h_%h exp=ffffffff_fffffffe", hi, lo);
            end
            tick();
            n++;
        end
        total++; if (n != 5) begin bad++; $display("FAIL multu_busy_len got=%0d exp=5", n); end
        total++; if (hi !== 32'h0000_0001) begin bad++; $display("FAIL multu_hi got=%h exp=00000001", hi); end
        total++; if (lo !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_lo got=%h exp=fffffffe", lo); end
    endtask

    task automatic test_div();
        int n;
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);   // -7 / 2
        wait_idle(n);
        total++; if (n != 10) begin bad++; $display("FAIL div_busy_len got=%0d exp=10", n); end
        total++; if (lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_lo got=%h exp=fffffffd", lo); end
        total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end

        issue(OP_DIVU, 32'd7, 32'd0);          // divide by zero
        wait_idle(n);
        total++; if (n != 10) begin bad++; $display("FAIL divz_busy_len got=%0d exp=10", n); end
        total++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            bad++; $display("FAIL divz_keep got=%h_%h exp=ffffffff_fffffffd", hi, lo);
        end

        issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);   // 7 / -2 = -3 r 1
        wait_idle(n);
        total++; if (hi !== 32'd1 || lo !== 32'hFFFF_FFFD) begin
            bad++; $display("FAIL div_negb got=%h_%h exp=00000001_fffffffd", hi, lo);
        end

        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        total++; if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
            bad++; $display("FAIL div_ovf got=%h_%h exp=00000000_80000000", hi, lo);
        end

        issue(OP_DIVU, 32'hFFFF_FFF9, 32'd2);  // 4294967289 / 2
        wait_idle(n);
        total++; if (hi !== 32'd1 || lo !== 32'h7FFF_FFFC) begin
            bad++; $display("FAIL divu got=%h_%h exp=00000001_7ffffffc", hi, lo);
        end
    endtask

    task automatic test_mt();
        int n;
        md_op = OP_MTHI; src_a = 32'h1234_5678; src_b = 32'd0;
        #1;
        total++; if (start !== 1'b0) begin bad++; $display("FAIL mthi_start got=%b exp=0", start); end
        tick();
        md_op = OP_NONE;
        total++; if (hi !== 32'h1234_5678) begin bad++; $display("FAIL mthi_hi got=%h exp=12345678", hi); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mthi_busy got=%b exp=0", busy); end

        issue(OP_MTLO, 32'hCAFE_BABE, 32'd0);
        total++; if (lo !== 32'hCAFE_BABE || hi !== 32'h1234_5678) begin
            bad++; $display("FAIL mtlo got=%h_%h exp=12345678_cafebabe", hi, lo);
        end

        issue(OP_MULTU, 32'd3, 32'd4);
        md_op = OP_MTLO; src_a = 32'hDEAD_BEEF;
        #1;
        total++; if (start !== 1'b0) begin bad++; $display("FAIL mtlo_busy_start got=%b exp=0", start); end
        tick();
        md_op = OP_MTHI; src_a = 32'hDEAD_BEEF;
        tick();
        md_op = OP_NONE;
        total++; if (hi !== 32'h1234_5678 || lo !== 32'hCAFE_BABE) begin
            bad++; $display("FAIL mt_during_busy got=%h_%h exp=12345678_cafebabe", hi, lo);
        end
        wait_idle(n);
        total++; if (n != 3) begin bad++; $display("FAIL mt_busy_rest got=%0d exp=3", n); end
        total++; if (hi !== 32'd0 || lo !== 32'd12) begin
            bad++; $display("FAIL mt_pending got=%h_%h exp=00000000_0000000c", hi, lo);
        end
    endtask

    task automatic test_reset_abort();
        issue(OP_MTHI, 32'hAAAA_5555, 32'd0);
        issue(OP_DIV, 32'd100, 32'd7);
        // Now in busy cycle 1; advance to busy cycle 4.
        tick();
        tick();
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy4 got=%b exp=1", busy); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            bad++; $display("FAIL abort_clear got=busy%b %h_%h exp=busy0 00000000_00000000", busy, hi, lo);
        end
        for (int i = 0; i < 12; i++) tick();
        total++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            bad++; $display("FAIL abort_late got=busy%b %h_%h exp=busy0 00000000_00000000", busy, hi, lo);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        issue(OP_MULT, 32'd3, 32'd5);
        // Second MULT is held on the inputs as a stalled ID instruction would be.
        md_op = OP_MULT; src_a = 32'hFFFF_FFFE; src_b = 32'd3;
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            total++; if (start !== 1'b0) begin bad++; $display("FAIL b2b_start_busy got=%b exp=0", start); end
            tick();
            n++;
        end
        total++; if (n != 5) begin bad++; $display("FAIL b2b_first_len got=%0d exp=5", n); end
        total++; if (hi !== 32'd0 || lo !== 32'd15) begin
            bad++; $display("FAIL b2b_first got=%h_%h exp=00000000_0000000f", hi, lo);
        end
        total++; if (start !== 1'b1) begin bad++; $display("FAIL b2b_start_fall got=%b exp=1", start); end
        tick();
        md_op = OP_NONE;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_second_busy got=%b exp=1", busy); end
        wait_idle(n);
        total++; if (n != 5) begin bad++; $display("FAIL b2b_second_len got=%0d exp=5", n); end
        total++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
            bad++; $display("FAIL b2b_second got=%h_%h exp=ffffffff_fffffffa", hi, lo);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_mt();
        test_reset_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
